multicycle_cpu_core: RTL

Parametrised multicycle CPU core and the next generation of the team's 18-bit single-datapath CPU. Widths are generalised via DATA_W/ADDR_W. A real FSM sequences fetch/decode/execute/memory/writeback over one shared ready/valid memory port with wait-state support. It has a 16-entry register file, a carry flag, branches, a halt state, and a synchronous PC clear.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/cpu_register_file.sv | 46 ++++
 rtl/multicycle_cpu_core.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the multicycle CPU core: the 4-bit opcode
// encoding, the sequencer state encoding and helpers that derive instruction
// field positions from the data width.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int OP_W       = 4;
   localparam int REG_ADDR_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'h0,
      OP_ADDI = 4'h1,
      OP_AND  = 4'h2,
      OP_ANDI = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_NAND = 4'h6,
      OP_SUB  = 4'h7,
      OP_LD   = 4'h8,
      OP_ST   = 4'h9,
      OP_JUMP = 4'hA,
      OP_BEQ  = 4'hB,
      OP_BLT  = 4'hC,
      OP_NOP0 = 4'hD,
      OP_NOP1 = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   // Field layout, MSB first: op | rd | rs1 | imm (rs2 overlaps the low 4 bits).
   function automatic int rd_lsb(input int data_w);
      return data_w - 8;
   endfunction

   function automatic int rs1_lsb(input int data_w);
      return data_w - 12;
   endfunction

   function automatic int imm_w(input int data_w);
      return data_w - 12;
   endfunction

endpackage

// File: rtl/cpu_register_file.sv
// -----------------------------------------------------------------------------
// cpu_register_file
// 16 x DATA_W register file: two asynchronous read ports, one synchronous
// write port. R0 always reads zero and ignores writes.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low clear
//   i_we, i_waddr, i_wdata    write port (sampled on rising i_clk)
//   i_raddr_a / o_rdata_a     read port A
//   i_raddr_b / o_rdata_b     read port B
// -----------------------------------------------------------------------------
module cpu_register_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = 18
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [REG_ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [REG_ADDR_W-1:0] i_raddr_a,
   input  logic [REG_ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0]     o_rdata_a,
   output logic [DATA_W-1:0]     o_rdata_b
);

   logic [DATA_W-1:0] r_regs [0:(1<<REG_ADDR_W)-1];

   // NOTE: the whole array is cleared on reset because software relies on
   // registers starting at zero; this forces flops rather than a RAM macro.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < (1 << REG_ADDR_W); i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         // NOTE: state updates use non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/multicycle_cpu_core.sv
// -----------------------------------------------------------------------------
// multicycle_cpu_core
// Multicycle CPU: BOOT -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH,
// sharing one ready/valid memory port for fetches, loads and stores.
// Parameters: DATA_W (>= 16), ADDR_W (<= DATA_W-4).
// Ports:
//   clock, resetN        rising-edge clock, asynchronous active-low reset
//   clearPC              sticky request: next fetch from 0; also leaves HALT
//   memReq/memWe/memAddr/memWdata   request side, held until memReady
//   memReady/memRdata    completion and read data
//   instruction, pc, carryOut, halted   architectural state visibility
// Optional (macro CPU_TRACE_EN): retireValid, retirePc retirement trace.
// -----------------------------------------------------------------------------
module multicycle_cpu_core
   import cpu_pkg::*;
#(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 14
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              clearPC,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic              memReady,
   input  logic [DATA_W-1:0] memRdata,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] pc,
   output logic              carryOut,
   output logic              halted
`ifdef CPU_TRACE_EN
   ,
   output logic              retireValid,
   output logic [ADDR_W-1:0] retirePc
`endif
);

   localparam int RD_LSB  = rd_lsb(DATA_W);
   localparam int RS1_LSB = rs1_lsb(DATA_W);
   localparam int IMM_W   = imm_w(DATA_W);

   state_e            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_ir, r_opa, r_opb, r_alu;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic              r_carry, r_clr_pend;

   // Instruction fields
   opcode_e                 w_op;
   logic [REG_ADDR_W-1:0]   w_rd, w_rs1, w_rs2, w_rb_addr;
   logic [DATA_W-1:0]       w_imm, w_rdata_a, w_rdata_b, w_b, w_alu;
   logic [DATA_W:0]         w_sum;
   logic [ADDR_W-1:0]       w_pc_inc, w_br_tgt;
   logic                    w_sub, w_eq, w_lt, w_clr, w_enter_fetch;

   assign w_op      = opcode_e'(r_ir[DATA_W-1 -: OP_W]);
   assign w_rd      = r_ir[RD_LSB +: REG_ADDR_W];
   assign w_rs1     = r_ir[RS1_LSB +: REG_ADDR_W];
   assign w_rs2     = r_ir[REG_ADDR_W-1:0];
   assign w_imm     = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
   // Port B carries rs2 for register-register ALU ops, otherwise R[rd]
   // (store data and the left operand of branch compares).
   assign w_rb_addr = (w_op inside {OP_ADD, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_SUB})
                      ? w_rs2 : w_rd;

   cpu_register_file #(.DATA_W(DATA_W)) u_regfile (
      .i_clk     (clock),
      .i_rst_n   (resetN),
      .i_we      (r_state == ST_WB),
      .i_waddr   (w_rd),
      .i_wdata   (r_alu),
      .i_raddr_a (w_rs1),
      .i_raddr_b (w_rb_addr),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   // ALU: subtract is a + ~b + 1, so the carry bit reads 1 for "no borrow".
   assign w_b   = (w_op inside {OP_ADDI, OP_ANDI, OP_LD, OP_ST}) ? w_imm : r_opb;
   assign w_sub = (w_op == OP_SUB);
   assign w_sum = {1'b0, r_opa} + {1'b0, (w_sub ? ~w_b : w_b)} + (DATA_W+1)'(w_sub);

   always_comb begin
      w_alu = w_sum[DATA_W-1:0];
      case (w_op)
         OP_AND, OP_ANDI: w_alu = r_opa & w_b;
         OP_OR:           w_alu = r_opa | w_b;
         OP_XOR:          w_alu = r_opa ^ w_b;
         OP_NAND:         w_alu = ~(r_opa & w_b);
         default:         ;
      endcase
   end

   assign w_eq     = (r_opb == r_opa);
   assign w_lt     = ($signed(r_opb) < $signed(r_opa));
   assign w_pc_inc = r_pc + ADDR_W'(1);
   assign w_br_tgt = w_pc_inc + w_imm[ADDR_W-1:0];
   assign w_clr    = r_clr_pend | clearPC;

   // Next-state and memory-port outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves one unassigned (which would infer a latch).
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      memReq      = 1'b0;
      memWe       = 1'b0;
      memAddr     = r_pc;
      case (r_state)
         ST_BOOT:   w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            memReq = 1'b1;
            if (memReady) w_state_nxt = ST_DECODE;
         end
         ST_DECODE: w_state_nxt = (w_op == OP_HALT) ? ST_HALT : ST_EXEC;
         ST_EXEC: begin
            w_state_nxt = ST_FETCH;
            w_pc_nxt    = w_pc_inc;
            case (w_op)
               OP_LD, OP_ST: begin
                  w_state_nxt = ST_MEM;
                  w_pc_nxt    = r_pc;
               end
               OP_JUMP:          w_pc_nxt = r_ir[ADDR_W-1:0];
               OP_BEQ:           if (w_eq) w_pc_nxt = w_br_tgt;
               OP_BLT:           if (w_lt) w_pc_nxt = w_br_tgt;
               OP_NOP0, OP_NOP1: ;
               default: begin
                  w_state_nxt = ST_WB;
                  w_pc_nxt    = r_pc;
               end
            endcase
         end
         ST_MEM: begin
            memReq  = 1'b1;
            memWe   = (w_op == OP_ST);
            memAddr = r_alu[ADDR_W-1:0];
            if (memReady) begin
               if (w_op == OP_ST) begin
                  w_state_nxt = ST_FETCH;
                  w_pc_nxt    = w_pc_inc;
               end else begin
                  w_state_nxt = ST_WB;
               end
            end
         end
         ST_WB: begin
            w_state_nxt = ST_FETCH;
            w_pc_nxt    = w_pc_inc;
         end
         ST_HALT:   if (w_clr) w_state_nxt = ST_FETCH;
         default:   w_state_nxt = ST_BOOT;
      endcase
      // A pending clear overrides whatever pc the finishing instruction chose.
      if ((w_state_nxt == ST_FETCH) && (r_state != ST_FETCH) && w_clr) begin
         w_pc_nxt = '0;
      end
   end

   assign w_enter_fetch = (w_state_nxt == ST_FETCH) && (r_state != ST_FETCH);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) r_state <= ST_BOOT;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_pc       <= '0;
         r_ir       <= '0;
         r_opa      <= '0;
         r_opb      <= '0;
         r_alu      <= '0;
         r_carry    <= 1'b0;
         r_clr_pend <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_clr_pend <= w_clr && !w_enter_fetch;
         if ((r_state == ST_FETCH) && memReady) r_ir <= memRdata;
         if (r_state == ST_DECODE) begin
            r_opa <= w_rdata_a;
            r_opb <= w_rdata_b;
         end
         if (r_state == ST_EXEC) begin
            r_alu <= w_alu;
            if (w_op inside {OP_ADD, OP_ADDI, OP_SUB}) r_carry <= w_sum[DATA_W];
         end
         // Load data reuses the ALU result register on its way to WB.
         if ((r_state == ST_MEM) && memReady) r_alu <= memRdata;
      end
   end

   assign memWdata    = r_opb;
   assign instruction = r_ir;
   assign pc          = r_pc;
   assign carryOut    = r_carry;
   assign halted      = (r_state == ST_HALT);

`ifdef CPU_TRACE_EN
   logic              r_retire_valid;
   logic [ADDR_W-1:0] r_retire_pc;
   logic              w_retire;

   // pc still holds the retiring instruction's address on its last cycle.
   assign w_retire = w_enter_fetch &&
                     (r_state inside {ST_EXEC, ST_MEM, ST_WB});

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_retire_valid <= 1'b0;
         r_retire_pc    <= '0;
      end else begin
         r_retire_valid <= w_retire;
         if (w_retire) r_retire_pc <= r_pc;
      end
   end

   assign retireValid = r_retire_valid;
   assign retirePc    = r_retire_pc;
`endif

endmodule
